// File: rtl/bus_pkg.sv
// Shared definitions for the peripheral bus master: FSM state encoding,
// default device count and data bus width.
package bus_pkg;

  localparam int BUS_W       = 32;
  localparam int DEF_NUM_DEV = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    TURN   = 2'd2
  } state_t;

endpackage

// File: rtl/bus_master_port_if.sv
// CPU-side request/completion handshake of the bus master port.
// The master modport belongs to the core and the slave modport to the port.
interface bus_master_port_if #(
  parameter int ADDR_W = 2
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              err;
  logic              busy;

  modport master (output req, we, addr, wdata, input rdata, done, err, busy);
  modport slave  (input req, we, addr, wdata, output rdata, done, err, busy);

endinterface

// File: rtl/irq_latch.sv
// Rising-edge interrupt collector: pending bits set on edge, cleared by ack
// (a same-cycle edge wins), and a registered masked OR request.
module irq_latch #(
  parameter int NUM_DEV = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_DEV-1:0] irq_in,
  input  logic [NUM_DEV-1:0] irq_mask,
  input  logic [NUM_DEV-1:0] irq_ack,
  output logic [NUM_DEV-1:0] irq_pending,
  output logic               irq_out
);

  logic [NUM_DEV-1:0] irq_dly_q;
  logic [NUM_DEV-1:0] pend_q;
  logic [NUM_DEV-1:0] pend_d;
  logic               out_q;
  logic               out_d;

  always_comb begin
    pend_d = (pend_q & ~irq_ack) | (irq_in & ~irq_dly_q);
    out_d  = |(pend_q & irq_mask);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_dly_q <= '0;
      pend_q    <= '0;
      out_q     <= 1'b0;
    end else begin
      irq_dly_q <= irq_in;
      pend_q    <= pend_d;
      out_q     <= out_d;
    end
  end

  assign irq_pending = pend_q;
  assign irq_out     = out_q;

endmodule

// File: rtl/bus_master_port.sv
// Initiator on the shared peripheral bus: single-word accesses with registered
// one-hot strobes and turnaround. Interrupt collection under BUS_MASTER_IRQ_EN.
module bus_master_port
  import bus_pkg::*;
#(
  parameter int NUM_DEV    = DEF_NUM_DEV,
  parameter int TURNAROUND = 1,
  parameter int ADDR_W     = $clog2(NUM_DEV)
) (
  input  logic               clock,
  input  logic               reset,
  bus_master_port_if.slave   cpu,
  inout  wire  [BUS_W-1:0]   data,
  output logic [NUM_DEV-1:0] read,
  output logic [NUM_DEV-1:0] write,
  input  logic [NUM_DEV-1:0] irq_in,
  input  logic [NUM_DEV-1:0] irq_mask,
  input  logic [NUM_DEV-1:0] irq_ack,
  output logic [NUM_DEV-1:0] irq_pending,
  output logic               irq_out
);

  localparam int SPACE = 1 << ADDR_W;
  localparam int CNT_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [CNT_W-1:0] LAST_TURN = CNT_W'(TURNAROUND - 1);
  // Bit i set when device index i exists; avoids a width-dependent compare.
  localparam logic [SPACE-1:0] DEV_MAP = SPACE'((64'd1 << NUM_DEV) - 64'd1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BUS_W-1:0]   wdata_q, wdata_d;
  logic [BUS_W-1:0]   rdata_q, rdata_d;
  logic [NUM_DEV-1:0] read_q, read_d, write_q, write_d;
  logic               drive_q, drive_d;
  logic               done_q, done_d, err_q, err_d, busy_q, busy_d;
  logic               dev_ok_s;
  logic [NUM_DEV-1:0] sel_s;

  assign dev_ok_s = DEV_MAP[cpu.addr];
  assign sel_s    = NUM_DEV'(1'b1) << addr_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (cpu.req) begin
          we_d    = cpu.we;
          addr_d  = cpu.addr;
          wdata_d = cpu.wdata;
          cnt_d   = '0;
          state_d = dev_ok_s ? STROBE : TURN;
        end else begin
          state_d = IDLE;
        end
      end
      STROBE: begin
        cnt_d   = '0;
        state_d = TURN;
      end
      TURN: begin
        if (cnt_q == LAST_TURN) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they align with it once registered.
  always_comb begin
    read_d  = '0;
    write_d = '0;
    drive_d = 1'b0;
    if (state_d == STROBE) begin
      if (we_d) begin
        write_d = sel_s;
        drive_d = 1'b1;
      end else begin
        read_d = sel_s;
      end
    end else begin
      drive_d = 1'b0;
    end
    done_d = (state_d == TURN) && (state_q != TURN);
    err_d  = (state_q == IDLE) && cpu.req && !dev_ok_s;
    busy_d = (state_d != IDLE);
    if ((state_q == STROBE) && !we_q) begin
      rdata_d = data;
    end else if (err_d && !cpu.we) begin
      rdata_d = '0;
    end else begin
      rdata_d = rdata_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      read_q  <= '0;
      write_q <= '0;
      drive_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      read_q  <= read_d;
      write_q <= write_d;
      drive_q <= drive_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  assign read      = read_q;
  assign write     = write_q;
  assign data      = drive_q ? wdata_q : {BUS_W{1'bz}};
  assign cpu.rdata = rdata_q;
  assign cpu.done  = done_q;
  assign cpu.err   = err_q;
  assign cpu.busy  = busy_q;

`ifdef BUS_MASTER_IRQ_EN
  irq_latch #(.NUM_DEV(NUM_DEV)) u_irq_latch (
    .clock      (clock),
    .reset      (reset),
    .irq_in     (irq_in),
    .irq_mask   (irq_mask),
    .irq_ack    (irq_ack),
    .irq_pending(irq_pending),
    .irq_out    (irq_out)
  );
`else
  wire unused_irq = ^{irq_in, irq_mask, irq_ack};
  assign irq_pending = '0;
  assign irq_out     = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: transaction-level timing model, vector table,
// corner-case sequences and randomized traffic. Works with or without BUS_MASTER_IRQ_EN.
module tb_bus_master_port;
  import bus_pkg::*;

  localparam int ND = 5;
  localparam int TA = 1;
  localparam int AW = $clog2(ND);
  localparam logic [31:0] IDLE_PAT = 32'h5A5A_A5A5;
  localparam logic [31:0] PAT3     = 32'h0F0F_0F0F;
`ifdef BUS_MASTER_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  bus_master_port_if #(.ADDR_W(AW)) cpu ();
  wire  [31:0]   data;
  logic [ND-1:0] rd_s, wr_s, irq_in, irq_mask, irq_ack, pend_s;
  logic          irq_out_s;
  logic          tb_drv;
  logic [31:0]   tb_val;
  assign data = tb_drv ? tb_val : 32'hzzzz_zzzz;

  bus_master_port #(.NUM_DEV(ND), .TURNAROUND(TA)) dut (
    .clock(clock), .reset(reset), .cpu(cpu), .data(data), .read(rd_s), .write(wr_s),
    .irq_in(irq_in), .irq_mask(irq_mask), .irq_ack(irq_ack),
    .irq_pending(pend_s), .irq_out(irq_out_s)
  );

  // Second instance: three devices, two turnaround cycles, bus held by a constant driver.
  bus_master_port_if #(.ADDR_W(2)) cpu3 ();
  wire  [31:0] data3;
  logic [2:0]  rd3, wr3, ip3, zero3;
  logic        io3;
  assign data3 = PAT3;

  bus_master_port #(.NUM_DEV(3), .TURNAROUND(2)) dut3 (
    .clock(clock), .reset(reset), .cpu(cpu3), .data(data3), .read(rd3), .write(wr3),
    .irq_in(zero3), .irq_mask(zero3), .irq_ack(zero3), .irq_pending(ip3), .irq_out(io3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: accepted transaction plus elapsed cycles since acceptance.
  int            cyc = 0;
  bit            acc_v = 1'b0;
  int            acc_c, acc_a;
  bit            acc_we, acc_oor;
  logic [31:0]   acc_wd;
  logic [31:0]   dev_mem [ND];
  logic [31:0]   exp_rdata;
  logic [ND-1:0] m_prev, m_pend;
  logic          m_out;
  logic [ND-1:0] e_rd, e_wr;
  logic          e_done, e_err, e_busy, e_drive;

  typedef struct {
    bit            we;
    int            addr;
    logic [31:0]   wdata;
    logic [ND-1:0] x_rd;
    logic [ND-1:0] x_wr;
    bit            x_err;
    logic [31:0]   x_rdata;
  } vec_t;
  vec_t tv [10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit model_idle();
    int k;
    if (!acc_v) return 1'b1;
    k = cyc - acc_c;
    return acc_oor ? (k >= 1 + TA) : (k >= 2 + TA);
  endfunction

  task automatic step();
    bit idle_prev;
    int k;
    @(posedge clock);
    #1;
    idle_prev = model_idle();
    if (reset) begin
      acc_v = 1'b0; exp_rdata = '0; m_prev = '0; m_pend = '0; m_out = 1'b0;
    end else begin
      if (cpu.req && idle_prev) begin
        acc_v = 1'b1; acc_c = cyc; acc_we = cpu.we; acc_a = int'(cpu.addr);
        acc_wd = cpu.wdata; acc_oor = (acc_a >= ND);
      end
      m_out  = |(m_pend & irq_mask);
      m_pend = (m_pend & ~irq_ack) | (irq_in & ~m_prev);
      m_prev = irq_in;
    end
    cyc++;
    e_rd = '0; e_wr = '0; e_done = 1'b0; e_err = 1'b0; e_busy = 1'b0; e_drive = 1'b0;
    if (acc_v) begin
      k = cyc - acc_c;
      if (!acc_oor) begin
        if (k == 1) begin
          if (acc_we) begin e_wr[acc_a] = 1'b1; e_drive = 1'b1; end
          else e_rd[acc_a] = 1'b1;
        end
        if (k == 2) begin
          e_done = 1'b1;
          if (!acc_we) exp_rdata = dev_mem[acc_a];
        end
        e_busy = (k <= 1 + TA);
      end else begin
        if (k == 1) begin
          e_done = 1'b1; e_err = 1'b1;
          if (!acc_we) exp_rdata = '0;
        end
        e_busy = (k <= TA);
      end
    end
    if (e_drive) tb_drv = 1'b0;
    else if (|e_rd) begin tb_drv = 1'b1; tb_val = dev_mem[acc_a]; end
    else begin tb_drv = 1'b1; tb_val = IDLE_PAT; end
    #1;
    check("read", 32'(rd_s), 32'(e_rd));
    check("write", 32'(wr_s), 32'(e_wr));
    check("done", 32'(cpu.done), 32'(e_done));
    if (e_done) check("err", 32'(cpu.err), 32'(e_err));
    check("busy", 32'(cpu.busy), 32'(e_busy));
    check("rdata", cpu.rdata, exp_rdata);
    check("data", data, e_drive ? acc_wd : ((|e_rd) ? dev_mem[acc_a] : IDLE_PAT));
    check("irq_pending", 32'(pend_s), IRQ_ON ? 32'(m_pend) : 32'h0);
    check("irq_out", 32'(irq_out_s), IRQ_ON ? 32'(m_out) : 32'h0);
    // Once the model's write strobe has passed the peripheral holds the new value.
    if (acc_v && !acc_oor && acc_we && (cyc - acc_c == 1)) dev_mem[acc_a] = acc_wd;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (!model_idle() && guard < 20) begin step(); guard++; end
    check("idle_wait", 32'(guard < 20), 32'h1);
  endtask

  task automatic do_req(input bit we, input int a, input logic [31:0] wd);
    wait_idle();
    cpu.req = 1'b1; cpu.we = we; cpu.addr = AW'(a); cpu.wdata = wd;
    step();
    cpu.req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ND-1:0] seen_rd, seen_wr;
    bit   got_done, got_err;
    logic [31:0] got_rdata;
    int   c0, wr_c, rd_c;

    tv[0] = '{1'b1, 2, 32'h0000_1234, 5'b00000, 5'b00100, 1'b0, 32'h0000_0000};
    tv[1] = '{1'b0, 0, 32'h0000_0000, 5'b00001, 5'b00000, 1'b0, 32'hDEAD_BEEF};
    tv[2] = '{1'b0, 2, 32'h0000_0000, 5'b00100, 5'b00000, 1'b0, 32'h0000_1234};
    tv[3] = '{1'b1, 4, 32'hCAFE_F00D, 5'b00000, 5'b10000, 1'b0, 32'h0000_1234};
    tv[4] = '{1'b0, 4, 32'h0000_0000, 5'b10000, 5'b00000, 1'b0, 32'hCAFE_F00D};
    tv[5] = '{1'b0, 5, 32'h0000_0000, 5'b00000, 5'b00000, 1'b1, 32'h0000_0000};
    tv[6] = '{1'b1, 7, 32'hFFFF_FFFF, 5'b00000, 5'b00000, 1'b1, 32'h0000_0000};
    tv[7] = '{1'b0, 1, 32'h0000_0000, 5'b00010, 5'b00000, 1'b0, 32'h1000_0001};
    tv[8] = '{1'b1, 3, 32'h0BAD_F00D, 5'b00000, 5'b01000, 1'b0, 32'h1000_0001};
    tv[9] = '{1'b0, 3, 32'h0000_0000, 5'b01000, 5'b00000, 1'b0, 32'h0BAD_F00D};

    dev_mem[0] = 32'hDEAD_BEEF;
    for (int i = 1; i < ND; i++) dev_mem[i] = 32'h1000_0000 + 32'(i);
    exp_rdata = '0; m_prev = '0; m_pend = '0; m_out = 1'b0;
    tb_drv = 1'b1; tb_val = IDLE_PAT;
    reset = 1'b1;
    cpu.req = 1'b0; cpu.we = 1'b0; cpu.addr = '0; cpu.wdata = '0;
    cpu3.req = 1'b0; cpu3.we = 1'b0; cpu3.addr = '0; cpu3.wdata = '0;
    irq_in = '0; irq_mask = '0; irq_ack = '0; zero3 = '0;

    repeat (3) step();
    check("rst_busy", 32'(cpu.busy), 32'h0);
    check("rst_strobes", 32'({rd_s, wr_s}), 32'h0);
    check("rst_rdata", cpu.rdata, 32'h0);
    reset = 1'b0;
    step();

    // Table of single accesses: strobes seen, err and rdata at the done cycle.
    for (int i = 0; i < 10; i++) begin
      do_req(tv[i].we, tv[i].addr, tv[i].wdata);
      seen_rd = rd_s; seen_wr = wr_s; got_done = 1'b0; got_err = 1'b0; got_rdata = '0;
      for (int n = 0; n < 8 && !got_done; n++) begin
        if (cpu.done) begin
          got_done = 1'b1; got_err = cpu.err; got_rdata = cpu.rdata;
        end else begin
          step(); seen_rd |= rd_s; seen_wr |= wr_s;
        end
      end
      check($sformatf("tv%0d_done", i), 32'(got_done), 32'h1);
      check($sformatf("tv%0d_rd", i), 32'(seen_rd), 32'(tv[i].x_rd));
      check($sformatf("tv%0d_wr", i), 32'(seen_wr), 32'(tv[i].x_wr));
      check($sformatf("tv%0d_err", i), 32'(got_err), 32'(tv[i].x_err));
      check($sformatf("tv%0d_rdata", i), got_rdata, tv[i].x_rdata);
    end

    // Back-to-back with req held: write dev1, then read dev1 offered while busy.
    wait_idle();
    c0 = cyc; wr_c = -1; rd_c = -1;
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = AW'(1); cpu.wdata = 32'h1111_2222;
    step();
    cpu.we = 1'b0;
    for (int n = 0; n < 10 && rd_c < 0; n++) begin
      if (wr_s[1] && wr_c < 0) wr_c = cyc - c0;
      if (rd_s[1]) rd_c = cyc - c0;
      else step();
    end
    cpu.req = 1'b0;
    check("b2b_write_cycle", 32'(wr_c), 32'd1);
    check("b2b_read_cycle", 32'(rd_c), 32'd4);
    step();
    check("b2b_rdata", cpu.rdata, 32'h1111_2222);

    // Reset asserted during the read strobe cycle.
    do_req(1'b0, 3, 32'h0);
    check("rst_mid_strobe", 32'(rd_s), 32'h8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_mid_read", 32'(rd_s), 32'h0);
    check("rst_mid_busy", 32'(cpu.busy), 32'h0);
    check("rst_mid_done", 32'(cpu.done), 32'h0);
    check("rst_mid_rdata", cpu.rdata, 32'h0);
    step();
    check("rst_mid_nodone", 32'(cpu.done), 32'h0);

    // Interrupt sequence.
    irq_mask = 5'b00010;
    step(); step();
    irq_in[1] = 1'b1;
    step();
    check("irq_set", 32'(pend_s), IRQ_ON ? 32'h2 : 32'h0);
    check("irq_out_lag", 32'(irq_out_s), 32'h0);
    irq_in[1] = 1'b0;
    step();
    check("irq_out", 32'(irq_out_s), IRQ_ON ? 32'h1 : 32'h0);
    irq_in[1] = 1'b1; irq_ack[1] = 1'b1;
    step();
    check("irq_set_wins", 32'(pend_s), IRQ_ON ? 32'h2 : 32'h0);
    step();
    check("irq_ack_clr", 32'(pend_s), 32'h0);
    irq_ack = '0; irq_in = '0;
    step();
    check("irq_out_clr", 32'(irq_out_s), 32'h0);
    irq_in[0] = 1'b1;
    step();
    check("irq_masked_pend", 32'(pend_s), IRQ_ON ? 32'h1 : 32'h0);
    step();
    check("irq_masked_out", 32'(irq_out_s), 32'h0);
    irq_in = '0;
    step();

    // Three-device instance: in-range read, then out-of-range read and write.
    cpu3.req = 1'b1; cpu3.we = 1'b0; cpu3.addr = 2'd1;
    step();
    cpu3.req = 1'b0;
    check("d3_rd_strobe", 32'(rd3), 32'h2);
    step();
    check("d3_done", 32'(cpu3.done), 32'h1);
    check("d3_rdata", cpu3.rdata, PAT3);
    step();
    check("d3_busy_turn2", 32'(cpu3.busy), 32'h1);
    step();
    check("d3_idle", 32'(cpu3.busy), 32'h0);
    cpu3.req = 1'b1; cpu3.addr = 2'd3;
    step();
    cpu3.req = 1'b0;
    check("d3_oor_strobes", 32'({rd3, wr3}), 32'h0);
    check("d3_oor_done", 32'(cpu3.done), 32'h1);
    check("d3_oor_err", 32'(cpu3.err), 32'h1);
    check("d3_oor_rdata", cpu3.rdata, 32'h0);
    step();
    check("d3_oor_busy", 32'(cpu3.busy), 32'h1);
    step();
    check("d3_oor_idle", 32'(cpu3.busy), 32'h0);
    cpu3.req = 1'b1; cpu3.we = 1'b1; cpu3.wdata = 32'hFFFF_FFFF;
    step();
    cpu3.req = 1'b0;
    check("d3_oorw_strobes", 32'({rd3, wr3}), 32'h0);
    check("d3_oorw_err", 32'(cpu3.err), 32'h1);
    check("d3_oorw_bus", data3, PAT3);
    step(); step();

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cpu.req   = ($urandom_range(0, 2) != 0);
      cpu.we    = 1'($urandom_range(0, 1));
      cpu.addr  = AW'($urandom_range(0, 7));
      cpu.wdata = $urandom();
      irq_in    = ND'($urandom());
      irq_mask  = ND'($urandom());
      irq_ack   = ($urandom_range(0, 3) == 0) ? ND'($urandom()) : '0;
      reset     = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0; cpu.req = 1'b0;
    step(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
